// File: rtl/irda_tx_framer_pkg.sv
// Shared IrDA definitions: FSM encoding, default frame timing and the
// parity helper used by both the transmit and receive paths.
package irda_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } tx_state_e;

   localparam int FRAME_BITS  = 12;
   localparam int SUBTICKS    = 16;
   localparam int PULSE_TICKS = 3;

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/irda_pulse_gen.sv
// Sub-tick counter and IR pulse comparator: a zero bit drives a short
// optical pulse at the start of its bit period, a one bit stays dark.
module irda_pulse_gen #(
   parameter int SUBTICKS    = irda_pkg::SUBTICKS,
   parameter int PULSE_TICKS = irda_pkg::PULSE_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic tick16,
   input  logic bit_val,
   output logic wrap,
   output logic ir_out
);
   import irda_pkg::*;

   localparam int SUB_W = (SUBTICKS > 1) ? $clog2(SUBTICKS) : 1;
   localparam logic [SUB_W-1:0] LAST_SUB  = SUB_W'(SUBTICKS - 1);
   localparam logic [SUB_W-1:0] PULSE_LIM = SUB_W'(PULSE_TICKS);

   logic [SUB_W-1:0] sub_r;
   logic             ir_out_r;

   assign wrap   = en & tick16 & (sub_r == LAST_SUB);
   assign ir_out = ir_out_r;

   // Sub-tick position within the bit and the registered pulse drive; both
   // are held at zero whenever the framer is not sending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_r    <= '0;
         ir_out_r <= 1'b0;
      end else if (!en) begin
         sub_r    <= '0;
         ir_out_r <= 1'b0;
      end else begin
         if (wrap) begin
            sub_r <= '0;
         end else if (tick16) begin
            sub_r <= sub_r + SUB_W'(1);
         end
         ir_out_r <= ~bit_val & (sub_r < PULSE_LIM);
      end
   end

endmodule

// File: rtl/irda_tx_framer.sv
// IrDA transmit framer: wraps a byte into start/data/parity/stop bits and
// paces them out through the pulse generator, driving an external bit_counter.
module irda_tx_framer #(
   parameter int FRAME_BITS  = irda_pkg::FRAME_BITS,
   parameter int SUBTICKS    = irda_pkg::SUBTICKS,
   parameter int PULSE_TICKS = irda_pkg::PULSE_TICKS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick16,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_ready,
   input  logic       bit_done,
   output logic       count,
   output logic       clear,
   output logic       irda_tx,
   output logic       frame_done
);
   import irda_pkg::*;

   localparam int STOP_BITS = FRAME_BITS - 10;

   tx_state_e             state_r;
   logic [FRAME_BITS-1:0] shreg_r;
   logic                  tx_ready_r;
   logic                  clear_r;
   logic                  send_s;
   logic                  wrap_s;
   logic                  ir_out_s;

   assign send_s = (state_r == SEND);

   // The bit_counter must see the increment in the wrap cycle itself, and the
   // end of frame is reported in the cycle bit_done is observed.
   assign count      = wrap_s & ~bit_done;
   assign frame_done = send_s & bit_done;
   assign tx_ready   = tx_ready_r;
   assign clear      = clear_r;
   assign irda_tx    = ir_out_s;

   irda_pulse_gen #(
      .SUBTICKS    (SUBTICKS),
      .PULSE_TICKS (PULSE_TICKS)
   ) u_pulse_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (send_s),
      .tick16  (tick16),
      .bit_val (shreg_r[0]),
      .wrap    (wrap_s),
      .ir_out  (ir_out_s)
   );

   // Frame sequencing; the shift register refills with ones so the line stays
   // dark once every frame bit has been sent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         shreg_r    <= '0;
         tx_ready_r <= 1'b1;
         clear_r    <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (tx_start) begin
                  state_r    <= LOAD;
                  shreg_r    <= {{STOP_BITS{1'b1}}, even_parity(tx_data), tx_data, 1'b0};
                  tx_ready_r <= 1'b0;
                  clear_r    <= 1'b1;
               end else begin
                  tx_ready_r <= 1'b1;
                  clear_r    <= 1'b1;
               end
            end
            LOAD: begin
               state_r    <= SEND;
               tx_ready_r <= 1'b0;
               clear_r    <= 1'b0;
            end
            SEND: begin
               if (bit_done) begin
                  state_r    <= IDLE;
                  tx_ready_r <= 1'b1;
                  clear_r    <= 1'b1;
               end else if (wrap_s) begin
                  shreg_r <= {1'b1, shreg_r[FRAME_BITS-1:1]};
               end
            end
            default: begin
               state_r    <= IDLE;
               tx_ready_r <= 1'b1;
               clear_r    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irda_tx_framer.sv
// Scoreboard bench for irda_tx_framer with a behavioural bit_counter and a
// frame-level reference model of the IrDA pulse pattern.
module tb_irda_tx_framer;

   logic       clk;
   logic       rst_n;
   logic       tick16;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_ready;
   logic       bit_done;
   logic       count;
   logic       clear;
   logic       irda_tx;
   logic       frame_done;
   logic       bd_inject;
   logic       tick_en;
   logic [3:0] bc_cnt = 4'd0;

   int tick_period;
   int div_cnt;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   int n_accepted = 0;
   int n_aborted = 0;
   int frames_seen = 0;

   logic [11:0] exp_q[$];

   bit active = 1'b0;
   int counts;
   int ticks;
   int last_cnt_cyc;
   int hi[12];
   int ptick[12];

   irda_tx_framer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick16     (tick16),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_ready   (tx_ready),
      .bit_done   (bit_done),
      .count      (count),
      .clear      (clear),
      .irda_tx    (irda_tx),
      .frame_done (frame_done)
   );

   // Downstream bit_counter: no reset of its own, only the framer's clear.
   assign bit_done = (bc_cnt == 4'd12) | bd_inject;
   always @(posedge clk) begin
      if (clear) bc_cnt <= 4'd0;
      else if (count) bc_cnt <= bc_cnt + 4'd1;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      tick16  = 1'b0;
      div_cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (div_cnt >= tick_period - 1) div_cnt = 0;
         else div_cnt++;
         tick16 = tick_en && (div_cnt == 0);
      end
   end

   // Reference: 1 means the bit period must carry a pulse (the bit is zero).
   function automatic logic [11:0] model_pulses(input logic [7:0] d);
      logic [11:0] bits;
      int ones = 0;
      for (int i = 0; i < 8; i++) begin
         ones += int'(d[i]);
         bits[i+1] = d[i];
      end
      bits[0]  = 1'b0;
      bits[9]  = (ones % 2 == 1);
      bits[10] = 1'b1;
      bits[11] = 1'b1;
      return ~bits;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got no event expected event", name);
   endtask

   always @(negedge clk) begin
      if (rst_n && tx_start && tx_ready) begin
         exp_q.push_back(model_pulses(tx_data));
         n_accepted++;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         active = 1'b0;
      end else begin
         if (!active && !clear) begin
            active = 1'b1;
            counts = 0;
            ticks  = 0;
            foreach (hi[i]) begin
               hi[i]    = 0;
               ptick[i] = 0;
            end
         end
         if (clear) check("idle_irda_dark", int'(irda_tx), 0);
         if (active) begin
            if (counts < 12) begin
               if (irda_tx) hi[counts]++;
               if (irda_tx && tick16) ptick[counts]++;
               if (tick16) ticks++;
            end
            if (count) begin
               check("count_while_bit_done", int'(bit_done), 0);
               counts++;
               last_cnt_cyc = cyc;
            end
         end else if (count) begin
            check("count_outside_frame", int'(count), 0);
         end
         if (frame_done) begin
            if (!active || exp_q.size() == 0) begin
               fail_now("frame_done_unexpected");
            end else begin
               logic [11:0] e;
               logic [11:0] obs;
               e = exp_q.pop_front();
               for (int i = 0; i < 12; i++) obs[i] = (hi[i] > 0);
               check("count_strobes", counts, 12);
               check("frame_ticks", ticks, 192);
               check("done_after_last_count", cyc - last_cnt_cyc, 1);
               check("pulse_pattern", int'(obs), int'(e));
               for (int i = 1; i < 12; i++) begin
                  if (e[i]) check("pulse_ticks", ptick[i], 3);
               end
               frames_seen++;
            end
            active = 1'b0;
         end
      end
   end

   task automatic start_frame(input logic [7:0] d, input logic inject);
      int i = 0;
      while (!tx_ready && i < 400) begin
         @(negedge clk);
         i++;
      end
      if (!tx_ready) fail_now("ready_timeout");
      @(posedge clk);
      #1;
      tx_data   = d;
      tx_start  = 1'b1;
      bd_inject = inject;
      @(posedge clk);
      #1;
      tx_start  = 1'b0;
      bd_inject = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (!frame_done && i < budget);
      if (!frame_done) fail_now("frame_done_timeout");
   endtask

   task automatic wait_counts(input int n);
      int c = 0;
      int i = 0;
      while (c < n && i < 2000) begin
         @(negedge clk);
         if (count) c++;
         i++;
      end
      if (c < n) fail_now("count_timeout");
   endtask

   initial begin
      int acc0;
      int i;
      rst_n       = 1'b0;
      tx_start    = 1'b0;
      tx_data     = 8'h00;
      bd_inject   = 1'b0;
      tick_en     = 1'b1;
      tick_period = 4;
      repeat (3) @(negedge clk);
      check("rst_irda_tx", int'(irda_tx), 0);
      check("rst_count", int'(count), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_tx_ready", int'(tx_ready), 1);
      check("rst_clear", int'(clear), 1);
      rst_n = 1'b1;

      start_frame(8'h00, 1'b0);
      wait_done(2000);
      start_frame(8'hFF, 1'b0);
      wait_done(2000);
      start_frame(8'hA5, 1'b0);
      wait_done(2000);
      start_frame(8'($urandom), 1'b1);
      wait_done(2000);

      // tx_start held across three frames with fresh data each frame
      acc0 = n_accepted;
      i = 0;
      while (!tx_ready && i < 400) begin
         @(negedge clk);
         i++;
      end
      @(posedge clk);
      #1;
      tx_data  = 8'($urandom);
      tx_start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_done(2000);
         if (k < 2) begin
            @(posedge clk);
            #1;
            tx_data = 8'($urandom);
            @(negedge clk);
            check("b2b_ready", int'(tx_ready), 1);
            @(negedge clk);
            check("b2b_load_clear", int'(clear), 1);
            @(negedge clk);
            check("b2b_send_clear", int'(clear), 0);
         end else begin
            @(posedge clk);
            #1;
            tx_start = 1'b0;
         end
      end
      repeat (4) @(negedge clk);
      check("held_accept_count", n_accepted - acc0, 3);

      // tick16 stalled at the start of bit 3 (a zero bit, so the pulse is on)
      start_frame(8'($urandom) & 8'hFB, 1'b0);
      wait_counts(3);
      @(posedge clk);
      #1;
      tick_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("stall_ir_level", int'(irda_tx), 1);
      repeat (100) begin
         @(negedge clk);
         check("stall_ir_frozen", int'(irda_tx), 1);
         check("stall_no_count", int'(count), 0);
      end
      @(posedge clk);
      #1;
      tick_en = 1'b1;
      wait_done(2000);

      // reset during the bit 5 pulse
      start_frame(8'($urandom) & 8'hEF, 1'b0);
      wait_counts(5);
      i = 0;
      while (!irda_tx && i < 40) begin
         @(negedge clk);
         i++;
      end
      check("bit5_pulse_seen", int'(irda_tx), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_irda_tx", int'(irda_tx), 0);
      check("abort_tx_ready", int'(tx_ready), 1);
      check("abort_clear", int'(clear), 1);
      check("abort_count", int'(count), 0);
      exp_q.delete();
      n_aborted++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_bit_counter", int'(bc_cnt), 0);
      check("abort_ready_after", int'(tx_ready), 1);

      for (int n = 0; n < 10; n++) begin
         tick_period = $urandom_range(1, 6);
         start_frame(8'($urandom), 1'b0);
         wait_done(2000);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      check("frames_completed", frames_seen, n_accepted - n_aborted);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
